// File: rtl/fifo_stream_reader_if.sv
// Purpose: bundles the FIFO read side and the valid/ready stream side of fifo_stream_reader.
// Latency: none, wires only.
// Backpressure: m_ready_i from the sink; fifo_rdreq_o toward the FIFO is credit-limited by the reader.
interface fifo_stream_reader_if #(
   parameter int DWIDTH = 8
);
   logic              fifo_empty_i;
   logic [DWIDTH-1:0] fifo_q_i;
   logic              fifo_rdreq_o;
   logic              m_valid_o;
   logic              m_ready_i;
   logic [DWIDTH-1:0] m_data_o;

   // Reader side: consumes FIFO status/data and sink ready, drives rdreq and the stream.
   modport slave (
      input  fifo_empty_i, fifo_q_i, m_ready_i,
      output fifo_rdreq_o, m_valid_o, m_data_o
   );

   // Environment side: FIFO plus stream sink.
   modport master (
      output fifo_empty_i, fifo_q_i, m_ready_i,
      input  fifo_rdreq_o, m_valid_o, m_data_o
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Purpose: drains a non-showahead FIFO via rdreq/q and re-presents the words as a valid/ready stream.
// Latency: RD_LATENCY+1 cycles from rdreq to m_valid_o with an empty skid buffer; 1 beat/cycle sustained.
// Backpressure: reads are issued only against free skid-buffer credits; FIFO_STREAM_READER_STATS_EN adds beat/stall counters.
module fifo_stream_reader #(
   parameter int DWIDTH     = 8,
   parameter int RD_LATENCY = 2,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                 clk_i,
   input  logic                 srst_n_i,
   fifo_stream_reader_if.slave  bus
`ifdef FIFO_STREAM_READER_STATS_EN
   ,
   output logic [31:0]          beat_cnt_o,
   output logic [31:0]          stall_cnt_o
`endif
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(BUF_DEPTH);
   localparam logic [CW-1:0] FULL_W  = CW'(BUF_DEPTH);

   logic [DWIDTH-1:0]     mem [BUF_DEPTH];
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;
   logic [CW-1:0]         buf_count;
   logic [RD_LATENCY-1:0] rv_pipe;
   logic [CW-1:0]         inflight;
   logic                  rdreq;
   logic                  capture;
   logic                  valid;
   logic                  pop;

   // Count reads still travelling through the FIFO output pipeline.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CW'(rv_pipe[i]);
      end
   end

   // Credit check uses registered state only, so a pop never feeds back into rdreq in the same cycle.
   assign rdreq   = srst_n_i & ~bus.fifo_empty_i &
                    (({1'b0, buf_count} + {1'b0, inflight}) < DEPTH_W);
   assign capture = rv_pipe[RD_LATENCY-1];
   assign valid   = (buf_count != '0);
   assign pop     = valid & bus.m_ready_i;

   assign bus.fifo_rdreq_o = rdreq;
   assign bus.m_valid_o    = valid;
   assign bus.m_data_o     = valid ? mem[head] : '0;

   // Track which cycles carry a valid read result; reset discards anything in flight.
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         rv_pipe <= '0;
      end else begin
         rv_pipe[0] <= rdreq;
         for (int i = 1; i < RD_LATENCY; i++) begin
            rv_pipe[i] <= rv_pipe[i-1];
         end
      end
   end

   // Skid buffer pointers and occupancy; capture and pop in one cycle leave the count unchanged.
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         head      <= '0;
         tail      <= '0;
         buf_count <= '0;
      end else begin
         if (capture) tail <= tail + PW'(1);
         if (pop)     head <= head + PW'(1);
         case ({capture, pop})
            2'b10:   buf_count <= buf_count + CW'(1);
            2'b01:   buf_count <= buf_count - CW'(1);
            default: buf_count <= buf_count;
         endcase
      end
   end

   // Buffer storage; the output mux masks stale entries so no reset is needed here.
   always_ff @(posedge clk_i) begin
      if (srst_n_i && capture) begin
         mem[tail] <= bus.fifo_q_i;
      end
   end

   // The credit rule makes overflow unreachable; catch it if that ever breaks.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!srst_n_i)
      !(capture && (buf_count == FULL_W) && !pop));

   a_no_read_empty: assert property (@(posedge clk_i) disable iff (!srst_n_i)
      !(bus.fifo_rdreq_o && bus.fifo_empty_i));

`ifdef FIFO_STREAM_READER_STATS_EN
   // Free-running accepted-beat and stalled-cycle counters, wrapping at 2^32.
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         beat_cnt_o  <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (pop)                       beat_cnt_o  <= beat_cnt_o + 32'd1;
         if (valid && !bus.m_ready_i)   stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule
